// File: rtl/rtl_pkg.sv
// Shared core types: memory opcodes, RV32I load/store funct3 codes, access
// sizes and the data-memory responder's FSM state and wait-counter width.
package rtl_pkg;

  localparam int DMEM_DEPTH     = 1024;
  localparam int DMEM_LAT_WIDTH = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [2:0] {
    FUNCT3_LB  = 3'b000,
    FUNCT3_LH  = 3'b001,
    FUNCT3_LW  = 3'b010,
    FUNCT3_LBU = 3'b100,
    FUNCT3_LHU = 3'b101
  } funct3_load_e;

  typedef enum logic [2:0] {
    FUNCT3_SB = 3'b000,
    FUNCT3_SH = 3'b001,
    FUNCT3_SW = 3'b010
  } funct3_store_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  function automatic logic [31:0] extend_lane(input logic [15:0] val,
                                              input logic        is_half,
                                              input logic        is_unsigned);
    logic [31:0] res;
    if (is_half) begin
      res = is_unsigned ? {16'h0000, val} : {{16{val[15]}}, val};
    end else begin
      res = is_unsigned ? {24'h000000, val[7:0]} : {{24{val[7]}}, val[7:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: op/funct3 decode, store byte enables and lane
// replication, load extraction with extension. DMEM_ALIGN_CHECK_EN selects
// whether misaligned accesses are rejected or forced to natural alignment.
module dmem_lane_align
  import rtl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        legal
);

  logic        legal_op_s;
  logic        is_load_s;
  logic        is_unsigned_s;
  logic [1:0]  size_s;
  logic [1:0]  lo_s;
  logic [15:0] lane_s;

  // Decode op/funct3 into access size, direction and signedness
  always_comb begin
    legal_op_s    = 1'b0;
    is_load_s     = 1'b0;
    is_unsigned_s = 1'b0;
    size_s        = SIZE_BYTE;
    case (op)
      MEM_READ: begin
        is_load_s = 1'b1;
        case (funct3)
          FUNCT3_LB:  begin legal_op_s = 1'b1; size_s = SIZE_BYTE; end
          FUNCT3_LH:  begin legal_op_s = 1'b1; size_s = SIZE_HALF; end
          FUNCT3_LW:  begin legal_op_s = 1'b1; size_s = SIZE_WORD; end
          FUNCT3_LBU: begin legal_op_s = 1'b1; size_s = SIZE_BYTE; is_unsigned_s = 1'b1; end
          FUNCT3_LHU: begin legal_op_s = 1'b1; size_s = SIZE_HALF; is_unsigned_s = 1'b1; end
          default:    legal_op_s = 1'b0;
        endcase
      end
      MEM_WRITE: begin
        case (funct3)
          FUNCT3_SB: begin legal_op_s = 1'b1; size_s = SIZE_BYTE; end
          FUNCT3_SH: begin legal_op_s = 1'b1; size_s = SIZE_HALF; end
          FUNCT3_SW: begin legal_op_s = 1'b1; size_s = SIZE_WORD; end
          default:   legal_op_s = 1'b0;
        endcase
      end
      default: legal_op_s = 1'b0;
    endcase
  end

  // Alignment policy: reject misaligned accesses, or snap them to size
  always_comb begin
    lo_s = addr_lo;
`ifdef DMEM_ALIGN_CHECK_EN
    legal = legal_op_s &&
            !(((size_s == SIZE_HALF) && addr_lo[0]) ||
              ((size_s == SIZE_WORD) && (addr_lo != 2'b00)));
`else
    legal = legal_op_s;
    case (size_s)
      SIZE_HALF: lo_s = {addr_lo[1], 1'b0};
      SIZE_WORD: lo_s = 2'b00;
      default:   lo_s = addr_lo;
    endcase
`endif
  end

  // Store enables/replication and load extraction/extension
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    rdata_ext   = 32'h0000_0000;
    lane_s      = lo_s[1] ? rword[31:16] : rword[15:0];
    if (legal && !is_load_s) begin
      case (size_s)
        SIZE_BYTE: begin byte_en = 4'b0001 << lo_s; wdata_lanes = {4{wdata[7:0]}}; end
        SIZE_HALF: begin byte_en = lo_s[1] ? 4'b1100 : 4'b0011; wdata_lanes = {2{wdata[15:0]}}; end
        default:   byte_en = 4'b1111;
      endcase
    end else if (legal) begin
      case (size_s)
        SIZE_BYTE: rdata_ext = extend_lane({8'h00, lo_s[0] ? lane_s[15:8] : lane_s[7:0]},
                                           1'b0, is_unsigned_s);
        SIZE_HALF: rdata_ext = extend_lane(lane_s, 1'b1, is_unsigned_s);
        default:   rdata_ext = rword;
      endcase
    end else begin
      rdata_ext = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels around
// word storage with LATENCY wait states (see dmem_lane_align for DMEM_ALIGN_CHECK_EN).
module dmem_responder
  import rtl_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DMEM_LAT_WIDTH-1:0] LAT_INIT =
    (LATENCY > 0) ? DMEM_LAT_WIDTH'(LATENCY - 1) : {DMEM_LAT_WIDTH{1'b0}};

  dmem_state_e               state_r, state_nxt_s;
  logic [DMEM_LAT_WIDTH-1:0] cnt_r;
  logic [1:0]                op_r;
  logic [2:0]                funct3_r;
  logic [31:0]               addr_r, wdata_r;
  logic                      req_ready_r, rsp_valid_r, rsp_err_r;
  logic [31:0]               rsp_rdata_r;
  logic                      accept_s, exec_s, rsp_hs_s, wr_en_s, in_range_s, legal_s;
  logic [1:0]                cur_op_s;
  logic [2:0]                cur_funct3_s;
  logic [31:0]               cur_addr_s, cur_wdata_s, rword_s, wlanes_s, rdata_ext_s;
  logic [IDX_W-1:0]          idx_s;
  logic [3:0]                byte_en_s;
  logic [31:0]               mem_q [DEPTH];

  assign accept_s = req_valid && req_ready_r;

  // With zero wait states the execute edge is the accepting edge, so the
  // datapath works on the live request in IDLE and on the captured one after.
  assign cur_op_s     = (state_r == IDLE) ? req_op     : op_r;
  assign cur_funct3_s = (state_r == IDLE) ? req_funct3 : funct3_r;
  assign cur_addr_s   = (state_r == IDLE) ? req_addr   : addr_r;
  assign cur_wdata_s  = (state_r == IDLE) ? req_wdata  : wdata_r;
  assign idx_s        = cur_addr_s[IDX_W+1:2];
  assign in_range_s   = (cur_addr_s >> (IDX_W + 2)) == 32'h0000_0000;
  assign rword_s      = mem_q[idx_s];

  dmem_lane_align u_lane (
    .op          (cur_op_s),
    .funct3      (cur_funct3_s),
    .addr_lo     (cur_addr_s[1:0]),
    .wdata       (cur_wdata_s),
    .rword       (rword_s),
    .byte_en     (byte_en_s),
    .wdata_lanes (wlanes_s),
    .rdata_ext   (rdata_ext_s),
    .legal       (legal_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_nxt_s = (LATENCY > 0) ? WAIT : RESP;
               else          state_nxt_s = IDLE;
      WAIT:    if (cnt_r == {DMEM_LAT_WIDTH{1'b0}}) state_nxt_s = RESP;
               else                                 state_nxt_s = WAIT;
      RESP:    if (rsp_ready) state_nxt_s = IDLE;
               else           state_nxt_s = RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output strobes: execute on RESP entry, handshake on RESP exit
  always_comb begin
    exec_s   = 1'b0;
    rsp_hs_s = 1'b0;
    wr_en_s  = 1'b0;
    if ((state_nxt_s == RESP) && (state_r != RESP)) begin
      exec_s  = 1'b1;
      wr_en_s = legal_s && in_range_s && (byte_en_s != 4'b0000);
    end else begin
      rsp_hs_s = (state_r == RESP) && rsp_ready;
    end
  end

  // Request capture, wait counter, ready and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= {DMEM_LAT_WIDTH{1'b0}};
      op_r        <= 2'b00;
      funct3_r    <= 3'b000;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == IDLE);
      if (accept_s) begin
        cnt_r    <= LAT_INIT;
        op_r     <= req_op;
        funct3_r <= req_funct3;
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
      end else if ((state_r == WAIT) && (cnt_r != {DMEM_LAT_WIDTH{1'b0}})) begin
        cnt_r <= cnt_r - {{(DMEM_LAT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (exec_s) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= !(legal_s && in_range_s);
        rsp_rdata_r <= (legal_s && in_range_s) ? rdata_ext_s : 32'h0000_0000;
      end else if (rsp_hs_s) begin
        rsp_valid_r <= 1'b0;
        rsp_err_r   <= 1'b0;
        rsp_rdata_r <= 32'h0000_0000;
      end
    end
  end

  // Storage write (contents deliberately not reset)
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_s[b]) mem_q[idx_s][8*b +: 8] <= wlanes_s[8*b +: 8];
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: DUT 0 has zero wait states, DUT 1 has three.
module tb_dmem_responder;
  import rtl_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [1:0]  req_op     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor side: pop the oldest expectation at every response handshake
  task automatic mon_pop(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected_rsp: got rdata=%h err=%b required no response",
               d, rsp_rdata[d], rsp_err[d]);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk({e.name, " rdata"}, rsp_rdata[d], e.rdata);
      chk({e.name, " err"}, {31'd0, rsp_err[d]}, {31'd0, e.err});
    end
  endtask

  always @(negedge clk) if (rst_n[0] && rsp_valid[0] && rsp_ready[0]) mon_pop(0);
  always @(negedge clk) if (rst_n[1] && rsp_valid[1] && rsp_ready[1]) mon_pop(1);

  // Present a request and wait (bounded) for its accepting edge; returns at edge+1
  task automatic send(input int d, input logic [1:0] op, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input logic push, input string name);
    exp_t e;
    logic acc;
    acc = 1'b0;
    if (push) begin
      e.rdata = exp_rd; e.err = exp_err; e.name = name;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    req_valid[d] = 1'b1; req_op[d] = op; req_funct3[d] = f3;
    req_addr[d] = addr; req_wdata[d] = wd;
    for (int i = 0; i < 20; i++) begin
      acc = req_ready[d];
      @(posedge clk); #1;
      if (acc) break;
    end
    req_valid[d] = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL %s accept_timeout: got no acceptance required acceptance within 20 cycles", name);
    end
  endtask

  // Latency counted in cycles from the acceptance cycle to the first valid cycle
  task automatic wait_rsp(input int d, input string name);
    int n;
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, (rsp_valid[d] === 1'b1) ? n : 32'hFFFF_FFFF, lat_of(d) + 1);
  endtask

  task automatic finish_rsp(input int d, input string name);
    @(posedge clk); #1;
    chk({name, " ready_after_hs"}, {31'd0, req_ready[d]}, 32'd1);
    chk({name, " valid_after_hs"}, {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  task automatic do_req(input int d, input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input string name);
    send(d, op, f3, addr, wd, exp_rd, exp_err, 1'b1, name);
    wait_rsp(d, name);
    finish_rsp(d, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_sh;
    logic        exp_sh_err;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_op[d] = 2'b00; req_funct3[d] = 3'b000;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset req_ready", {31'd0, req_ready[d]}, 32'd0);
      chk("reset rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("reset rsp_rdata", rsp_rdata[d], 32'h0);
      chk("reset rsp_err", {31'd0, rsp_err[d]}, 32'd0);
      rst_n[d] = 1'b1;
    end
    @(posedge clk); #1;
    chk("release ready0", {31'd0, req_ready[0]}, 32'd1);
    chk("release ready1", {31'd0, req_ready[1]}, 32'd1);

    // Zero-latency word and sub-word traffic
    do_req(0, MEM_WRITE, FUNCT3_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    do_req(0, MEM_READ,  FUNCT3_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    do_req(0, MEM_WRITE, FUNCT3_SB, 32'h11, 32'h0000005A, 32'h0, 1'b0, "sb_11");
    do_req(0, MEM_READ,  FUNCT3_LW,  32'h10, 32'h0, 32'hDEAD5AEF, 1'b0, "lw_10b");
    do_req(0, MEM_READ,  FUNCT3_LB,  32'h11, 32'h0, 32'h0000005A, 1'b0, "lb_11");
    do_req(0, MEM_READ,  FUNCT3_LH,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_12");
    do_req(0, MEM_READ,  FUNCT3_LHU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, "lhu_12");
    do_req(0, MEM_READ,  FUNCT3_LB,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_13");
    do_req(0, MEM_READ,  FUNCT3_LBU, 32'h10, 32'h0, 32'h000000EF, 1'b0, "lbu_10");

    // Misaligned half store and word load
    do_req(0, MEM_WRITE, FUNCT3_SW, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "sw_20");
`ifdef DMEM_ALIGN_CHECK_EN
    exp_sh = 32'hCAFEF00D; exp_sh_err = 1'b1;
`else
    exp_sh = 32'hCAFE1234; exp_sh_err = 1'b0;
`endif
    do_req(0, MEM_WRITE, FUNCT3_SH, 32'h21, 32'h00001234, 32'h0, exp_sh_err, "sh_21");
    do_req(0, MEM_READ,  FUNCT3_LW, 32'h22, 32'h0, exp_sh_err ? 32'h0 : exp_sh, exp_sh_err, "lw_22");
    do_req(0, MEM_READ,  FUNCT3_LW, 32'h20, 32'h0, exp_sh, 1'b0, "lw_20");

    // Illegal requests must not write
    do_req(0, MEM_WRITE, FUNCT3_SW, 32'h30, 32'h11223344, 32'h0, 1'b0, "sw_30");
    do_req(0, MEM_WRITE, FUNCT3_SW, 32'h00, 32'h0BADF00D, 32'h0, 1'b0, "sw_00");
    do_req(0, 2'b11,     FUNCT3_SW, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, "op_11");
    do_req(0, MEM_NONE,  FUNCT3_SW, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, "op_00");
    do_req(0, MEM_READ,  3'b011,    32'h30, 32'h0, 32'h0, 1'b1, "ld_f3_011");
    do_req(0, MEM_WRITE, 3'b011,    32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, "st_f3_011");
    do_req(0, MEM_WRITE, FUNCT3_SW, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_1000");
    do_req(0, MEM_READ,  FUNCT3_LW, 32'h1000, 32'h0, 32'h0, 1'b1, "lw_1000");
    do_req(0, MEM_READ,  FUNCT3_LW, 32'h30, 32'h0, 32'h11223344, 1'b0, "lw_30");
    do_req(0, MEM_READ,  FUNCT3_LW, 32'h00, 32'h0, 32'h0BADF00D, 1'b0, "lw_00");

    // Three wait states, with a five-cycle response stall
    do_req(1, MEM_WRITE, FUNCT3_SW, 32'h40, 32'h55AA55AA, 32'h0, 1'b0, "l3_sw_40");
    rsp_ready[1] = 1'b0;
    send(1, MEM_READ, FUNCT3_LW, 32'h40, 32'h0, 32'h55AA55AA, 1'b0, 1'b1, "l3_lw_stall");
    wait_rsp(1, "l3_lw_stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall rsp_valid", {31'd0, rsp_valid[1]}, 32'd1);
      chk("stall rsp_rdata", rsp_rdata[1], 32'h55AA55AA);
      chk("stall req_ready", {31'd0, req_ready[1]}, 32'd0);
    end
    rsp_ready[1] = 1'b1;
    finish_rsp(1, "l3_lw_stall");

    // Reset while the store waits: dropped, no write, no response
    send(1, MEM_WRITE, FUNCT3_SW, 32'h40, 32'h99999999, 32'h0, 1'b0, 1'b0, "l3_sw_drop");
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    chk("midrst req_ready", {31'd0, req_ready[1]}, 32'd0);
    chk("midrst rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    chk("post_rst req_ready", {31'd0, req_ready[1]}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    do_req(1, MEM_READ, FUNCT3_LW, 32'h40, 32'h0, 32'h55AA55AA, 1'b0, "l3_lw_after_rst");

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard0 empty", q0.size(), 32'd0);
    chk("scoreboard1 empty", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
